// File: rtl/demux_pingpong_wr_ctrl.sv
// Write-side ping-pong controller: fills bank 1 then bank 2 with DEPTH words each,
// steering bytes through demux_1_to_2_8bits. Optional flush/fill_level behind DEMUX_FLUSH_EN.

module demux_1_to_2_8bits (
    input  logic       i_sel,
    input  logic       i_en,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout_1,
    output logic [7:0] o_dout_2
);
    always_comb begin
        o_dout_1 = 8'h00;
        o_dout_2 = 8'h00;
        if (i_en) begin
            if (i_sel) o_dout_2 = i_din;
            else       o_dout_1 = i_din;
        end
    end
endmodule

module demux_pingpong_wr_ctrl #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic [7:0]        din,
    output logic              din_ready,
    input  logic [1:0]        bank_release,
`ifdef DEMUX_FLUSH_EN
    input  logic              flush,
    output logic [ADDR_W:0]   fill_level,
`endif
    output logic [7:0]        dout_1,
    output logic [7:0]        dout_2,
    output logic              wr_en_1,
    output logic              wr_en_2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        bank_full,
    output logic              bank_done,
    output logic              cur_bank
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_cur_bank;
    logic [1:0]        r_bank_full;
    logic              r_bank_done;
    logic              r_wr_en_1;
    logic              r_wr_en_2;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_dout_1;
    logic [7:0]        r_dout_2;

    logic              w_accept;
    logic              w_last;
    logic              w_close;
    logic              w_other;
    logic              w_stall;
    logic [1:0]        w_full_next;
    logic [7:0]        w_demux_1;
    logic [7:0]        w_demux_2;

    assign din_ready = (r_state == S_FILL);
    assign w_accept  = din_valid & din_ready;
    assign w_last    = w_accept && (r_wr_cnt == LAST_ADDR);

`ifdef DEMUX_FLUSH_EN
    logic [ADDR_W:0] r_fill_level;
    logic [ADDR_W:0] w_words;

    // A flush closes the bank only if it holds at least one word, counting one accepted now.
    assign w_close = w_last | (flush && (r_state == S_FILL) && ((r_wr_cnt != '0) || w_accept));
    assign w_words = {1'b0, r_wr_cnt} + (ADDR_W + 1)'(w_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_fill_level <= '0;
        else if (w_close) r_fill_level <= w_words;
    end

    assign fill_level = r_fill_level;
`else
    assign w_close = w_last;
`endif

    // Stall after closing a bank if the other bank is still held and not freed this cycle.
    assign w_other = ~r_cur_bank;
    assign w_stall = r_bank_full[w_other] & ~bank_release[w_other];

    // Release clears first, then a close sets; a same-bank release is thus ignored.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_full
            assign w_full_next[gi] = (r_bank_full[gi] & ~bank_release[gi])
                                   | (w_close && (r_cur_bank == 1'(gi)));
        end
    endgenerate

    demux_1_to_2_8bits u_demux (
        .i_sel    (r_cur_bank),
        .i_en     (w_accept),
        .i_din    (din),
        .o_dout_1 (w_demux_1),
        .o_dout_2 (w_demux_2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_wr_cnt    <= '0;
            r_cur_bank  <= 1'b0;
            r_bank_full <= 2'b00;
            r_bank_done <= 1'b0;
        end else begin
            r_bank_full <= w_full_next;
            r_bank_done <= w_close;
            case (r_state)
                S_FILL: begin
                    if (w_close) begin
                        r_wr_cnt   <= '0;
                        r_cur_bank <= ~r_cur_bank;
                        r_state    <= w_stall ? S_WAIT : S_FILL;
                    end else if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bank_release[r_cur_bank]) r_state <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en_1 <= 1'b0;
            r_wr_en_2 <= 1'b0;
            r_wr_addr <= '0;
            r_dout_1  <= 8'h00;
            r_dout_2  <= 8'h00;
        end else begin
            r_wr_en_1 <= w_accept & ~r_cur_bank;
            r_wr_en_2 <= w_accept &  r_cur_bank;
            r_dout_1  <= w_demux_1;
            r_dout_2  <= w_demux_2;
            if (w_accept) r_wr_addr <= r_wr_cnt;
        end
    end

    assign dout_1    = r_dout_1;
    assign dout_2    = r_dout_2;
    assign wr_en_1   = r_wr_en_1;
    assign wr_en_2   = r_wr_en_2;
    assign wr_addr   = r_wr_addr;
    assign bank_full = r_bank_full;
    assign bank_done = r_bank_done;
    assign cur_bank  = r_cur_bank;
endmodule

// File: tb/tb_demux_pingpong_wr_ctrl.sv
// Directed bench for demux_pingpong_wr_ctrl at DEPTH=4; flush scenario runs when DEMUX_FLUSH_EN is defined.

module tb_demux_pingpong_wr_ctrl;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              din_valid;
    logic [7:0]        din;
    logic              din_ready;
    logic [1:0]        bank_release;
    logic [7:0]        dout_1;
    logic [7:0]        dout_2;
    logic              wr_en_1;
    logic              wr_en_2;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        bank_full;
    logic              bank_done;
    logic              cur_bank;
`ifdef DEMUX_FLUSH_EN
    logic              flush;
    logic [ADDR_W:0]   fill_level;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_pingpong_wr_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .din          (din),
        .din_ready    (din_ready),
        .bank_release (bank_release),
`ifdef DEMUX_FLUSH_EN
        .flush        (flush),
        .fill_level   (fill_level),
`endif
        .dout_1       (dout_1),
        .dout_2       (dout_2),
        .wr_en_1      (wr_en_1),
        .wr_en_2      (wr_en_2),
        .wr_addr      (wr_addr),
        .bank_full    (bank_full),
        .bank_done    (bank_done),
        .cur_bank     (cur_bank)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din_valid = 1'b0; din = 8'h00; bank_release = 2'b00;
`ifdef DEMUX_FLUSH_EN
        flush = 1'b0;
`endif
        tick(); tick();
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
        checks++; if ({wr_en_1, wr_en_2} !== 2'b00) begin errors++; $display("FAIL reset_wr_en got=%b exp=00", {wr_en_1, wr_en_2}); end
        checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL reset_full got=%b exp=00", bank_full); end
        checks++; if (cur_bank !== 1'b0) begin errors++; $display("FAIL reset_cur got=%b exp=0", cur_bank); end
        checks++; if (bank_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bank_done); end
        $display("reset: ready=%b full=%b cur=%b", din_ready, bank_full, cur_bank);
        rst_n = 1'b1;
        tick();
    endtask

    // Writes 4 words starting at base into bank b (0=bank 1); rel is driven with the last word.
    task automatic fill_bank(input logic [7:0] base, input logic b, input logic [1:0] rel, input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            din_valid = 1'b1;
            din = base + 8'(i);
            bank_release = (i == DEPTH - 1) ? rel : 2'b00;
            checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL %s_ready word=%0d got=%b exp=1", tag, i, din_ready); end
            tick();
            $display("%s: din=%h wr_en=%b%b addr=%0d d1=%h d2=%h", tag, din, wr_en_1, wr_en_2, wr_addr, dout_1, dout_2);
            checks++;
            if ({wr_en_1, wr_en_2} !== (b ? 2'b01 : 2'b10) || wr_addr !== 2'(i)
                || (b ? dout_2 : dout_1) !== base + 8'(i) || (b ? dout_1 : dout_2) !== 8'h00) begin
                errors++;
                $display("FAIL %s_write word=%0d got en=%b%b addr=%0d d1=%h d2=%h exp bank=%0d addr=%0d data=%h",
                         tag, i, wr_en_1, wr_en_2, wr_addr, dout_1, dout_2, b, i, base + 8'(i));
            end
        end
        din_valid = 1'b0; bank_release = 2'b00;
    endtask

    task automatic test_fill_bank1();
        fill_bank(8'h10, 1'b0, 2'b00, "fill1");
        checks++; if (bank_done !== 1'b1) begin errors++; $display("FAIL fill1_done got=%b exp=1", bank_done); end
        checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL fill1_full got=%b exp=01", bank_full); end
        checks++; if (cur_bank !== 1'b1) begin errors++; $display("FAIL fill1_cur got=%b exp=1", cur_bank); end
        tick();
        checks++; if (bank_done !== 1'b0) begin errors++; $display("FAIL fill1_done_pulse got=%b exp=0", bank_done); end
    endtask

    task automatic test_stall();
        fill_bank(8'h20, 1'b1, 2'b00, "fill2");
        checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL stall_full got=%b exp=11", bank_full); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", din_ready); end
        din_valid = 1'b1; din = 8'h24;
        tick();
        checks++; if ({wr_en_1, wr_en_2} !== 2'b00 || din_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got en=%b%b ready=%b exp en=00 ready=0", wr_en_1, wr_en_2, din_ready); end
        bank_release = 2'b01;
        tick();
        bank_release = 2'b00;
        $display("release: ready=%b full=%b", din_ready, bank_full);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", din_ready); end
        checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL release_full got=%b exp=10", bank_full); end
        tick();
        $display("held: wr_en=%b%b addr=%0d d1=%h", wr_en_1, wr_en_2, wr_addr, dout_1);
        checks++; if ({wr_en_1, wr_en_2} !== 2'b10 || wr_addr !== 2'd0 || dout_1 !== 8'h24) begin errors++; $display("FAIL held_write got en=%b%b addr=%0d d1=%h exp en=10 addr=0 d1=24", wr_en_1, wr_en_2, wr_addr, dout_1); end
        // Free bank 2 mid-block, then finish bank 1 without stalling.
        din = 8'h25; bank_release = 2'b10;
        tick();
        bank_release = 2'b00;
        checks++; if (bank_full !== 2'b00 || wr_addr !== 2'd1 || dout_1 !== 8'h25) begin errors++; $display("FAIL mid_release got full=%b addr=%0d d1=%h exp full=00 addr=1 d1=25", bank_full, wr_addr, dout_1); end
        din = 8'h26; tick();
        din = 8'h27; tick();
        din_valid = 1'b0;
        checks++; if (bank_full !== 2'b01 || cur_bank !== 1'b1 || din_ready !== 1'b1 || wr_addr !== 2'd3) begin errors++; $display("FAIL refill1 got full=%b cur=%b ready=%b addr=%0d exp full=01 cur=1 ready=1 addr=3", bank_full, cur_bank, din_ready, wr_addr); end
    endtask

    task automatic test_same_cycle_release();
        fill_bank(8'h30, 1'b1, 2'b01, "overlap");
        $display("overlap: full=%b ready=%b cur=%b done=%b", bank_full, din_ready, cur_bank, bank_done);
        checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL overlap_full got=%b exp=10", bank_full); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL overlap_ready got=%b exp=1", din_ready); end
        checks++; if (cur_bank !== 1'b0 || bank_done !== 1'b1) begin errors++; $display("FAIL overlap_cur got cur=%b done=%b exp cur=0 done=1", cur_bank, bank_done); end
    endtask

    task automatic test_bubbles();
        logic       v;
        logic [1:0] exp_addr;
        exp_addr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v = (i % 2 == 0);
            din_valid = v; din = 8'h40 + 8'(i);
            tick();
            $display("bubble %0d: valid=%b wr_en=%b%b addr=%0d d1=%h", i, v, wr_en_1, wr_en_2, wr_addr, dout_1);
            if (v) begin
                checks++; if ({wr_en_1, wr_en_2} !== 2'b10 || wr_addr !== exp_addr || dout_1 !== 8'h40 + 8'(i)) begin errors++; $display("FAIL bubble_write cyc=%0d got en=%b%b addr=%0d d1=%h exp en=10 addr=%0d d1=%h", i, wr_en_1, wr_en_2, wr_addr, dout_1, exp_addr, 8'h40 + 8'(i)); end
                exp_addr = exp_addr + 2'd1;
            end else begin
                checks++; if ({wr_en_1, wr_en_2} !== 2'b00) begin errors++; $display("FAIL bubble_idle cyc=%0d got en=%b%b exp=00", i, wr_en_1, wr_en_2); end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        // Two words already sit in bank 1 and bank 2 is full at this point.
        rst_n = 1'b0;
        #1;
        $display("mid reset: full=%b cur=%b ready=%b", bank_full, cur_bank, din_ready);
        checks++; if (bank_full !== 2'b00 || cur_bank !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL midrst_state got full=%b cur=%b ready=%b exp full=00 cur=0 ready=1", bank_full, cur_bank, din_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        din_valid = 1'b1; din = 8'h50;
        tick();
        din_valid = 1'b0;
        $display("post reset: wr_en=%b%b addr=%0d d1=%h", wr_en_1, wr_en_2, wr_addr, dout_1);
        checks++; if ({wr_en_1, wr_en_2} !== 2'b10 || wr_addr !== 2'd0 || dout_1 !== 8'h50) begin errors++; $display("FAIL midrst_write got en=%b%b addr=%0d d1=%h exp en=10 addr=0 d1=50", wr_en_1, wr_en_2, wr_addr, dout_1); end
    endtask

`ifdef DEMUX_FLUSH_EN
    task automatic test_flush();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        din_valid = 1'b1; din = 8'h60; tick();
        din = 8'h61; tick();
        din_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("flush: done=%b level=%0d cur=%b full=%b", bank_done, fill_level, cur_bank, bank_full);
        checks++; if (bank_done !== 1'b1 || fill_level !== 3'd2) begin errors++; $display("FAIL flush_done got done=%b level=%0d exp done=1 level=2", bank_done, fill_level); end
        checks++; if (cur_bank !== 1'b1 || bank_full !== 2'b01) begin errors++; $display("FAIL flush_state got cur=%b full=%b exp cur=1 full=01", cur_bank, bank_full); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (bank_done !== 1'b0 || cur_bank !== 1'b1) begin errors++; $display("FAIL flush_empty got done=%b cur=%b exp done=0 cur=1", bank_done, cur_bank); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_bank1();
        test_stall();
        test_same_cycle_release();
        test_bubbles();
        test_reset_mid_block();
`ifdef DEMUX_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout sim_time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end
endmodule
